// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive-side datapath.
package uart_pkg;

    localparam int unsigned UART_BYTE_BITS  = 8;
    localparam int unsigned DROP_COUNT_BITS = 16;

    typedef logic [UART_BYTE_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner guarantees unwritten words are never observed.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_BITS-1:0] wr_addr,
    input  uart_byte_t            wr_data,
    input  logic [DEPTH_BITS-1:0] rd_addr,
    output uart_byte_t            rd_data
);

    localparam int unsigned DEPTH = 2 ** DEPTH_BITS;

    uart_byte_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: byte strobe in, valid/ready out, level and sticky overflow.
// Define UART_RX_FIFO_DROP_COUNT_EN to add a saturating 16-bit dropped-byte counter (drop_count).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  uart_byte_t            rx_data,
    input  logic                  rx_data_ready,
    output uart_byte_t            read_data,
    output logic                  read_valid,
    input  logic                  read_ready,
    output logic [DEPTH_BITS:0]   level,
    output logic                  overflow,
    input  logic                  overflow_clear
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    ,
    output logic [DROP_COUNT_BITS-1:0] drop_count
`endif
);

    typedef logic [DEPTH_BITS:0] ptr_t;

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic       overflow_q, overflow_d;
    logic       empty, full;
    logic       push, pop, drop;
    uart_byte_t mem_rd_data;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);

    assign push = rx_data_ready && !full;
    assign drop = rx_data_ready && full;
    assign pop  = !empty && read_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
        end
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [DROP_COUNT_BITS-1:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (overflow_clear) begin
            drop_count_d = drop ? DROP_COUNT_BITS'(1) : '0;
        end else if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + DROP_COUNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    uart_rx_fifo_mem #(
        .DEPTH_BITS (DEPTH_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[DEPTH_BITS-1:0]),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q[DEPTH_BITS-1:0]),
        .rd_data (mem_rd_data)
    );

    // Gate the head word so nothing from uninitialised memory leaks out while empty.
    assign read_data  = empty ? '0 : mem_rd_data;
    assign read_valid = !empty;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH_BITS = 4;
    localparam int unsigned DEPTH      = 2 ** DEPTH_BITS;

    logic                clk;
    logic                reset_n;
    logic [7:0]          rx_data;
    logic                rx_data_ready;
    logic [7:0]          read_data;
    logic                read_valid;
    logic                read_ready;
    logic [DEPTH_BITS:0] level;
    logic                overflow;
    logic                overflow_clear;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    logic [15:0]         drop_count;
`endif

    uart_rx_fifo #(
        .DEPTH_BITS (DEPTH_BITS)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .read_ready     (read_ready),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain byte queue plus the two sticky status values.
    logic [7:0] model_q [$];
    logic [7:0] popped_q [$];
    logic       model_ovf;
    int         model_drops;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("level", 32'(level), 32'(model_q.size()));
        check_eq("read_valid", 32'(read_valid), 32'(model_q.size() != 0));
        check_eq("overflow", 32'(overflow), 32'(model_ovf));
        if (model_q.size() != 0) begin
            check_eq("read_data", 32'(read_data), 32'(model_q[0]));
        end
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        check_eq("drop_count", 32'(drop_count), 32'(model_drops));
`endif
    endtask

    // Apply one cycle of inputs, advance the model with the pre-edge state, compare after the edge.
    task automatic cycle(input logic strobe, input logic [7:0] d, input logic rr, input logic clr);
        bit was_full;
        bit do_pop;
        rx_data        = d;
        rx_data_ready  = strobe;
        read_ready     = rr;
        overflow_clear = clr;
        @(posedge clk);
        #1;
        was_full = (model_q.size() == DEPTH);
        do_pop   = (model_q.size() != 0) && rr;
        if (do_pop) popped_q.push_back(model_q.pop_front());
        if (strobe && !was_full) model_q.push_back(d);
        if (strobe && was_full) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
        if (clr) model_drops = (strobe && was_full) ? 1 : 0;
        else if (strobe && was_full && model_drops != 65535) model_drops++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (model_q.size() != 0 && guard < 4 * DEPTH) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end
        check_eq("drain_done", 32'(read_valid), 32'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf   = 1'b0;
        model_drops = 0;
        check_eq("rst_read_valid", 32'(read_valid), 32'(0));
        check_eq("rst_level", 32'(level), 32'(0));
        check_eq("rst_overflow", 32'(overflow), 32'(0));
`ifdef UART_RX_FIFO_DROP_COUNT_EN
        check_eq("rst_drop_count", 32'(drop_count), 32'(0));
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [7:0] lfsr;
    logic [7:0] lfsr_seq [$];

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        model_ovf      = 1'b0;
        model_drops    = 0;
        rx_data        = 8'h00;
        rx_data_ready  = 1'b0;
        read_ready     = 1'b0;
        overflow_clear = 1'b0;
        reset_n        = 1'b1;
        #2;
        do_reset();
        check_eq("rst_read_data", 32'(read_data), 32'(8'h00));

        // 1. Basic ordering, no fall-through.
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        popped_q.delete();
        drain();
        check_eq("t1_count", 32'(popped_q.size()), 32'(3));
        if (popped_q.size() == 3) begin
            check_eq("t1_b0", 32'(popped_q[0]), 32'(8'hA5));
            check_eq("t1_b1", 32'(popped_q[1]), 32'(8'h3C));
            check_eq("t1_b2", 32'(popped_q[2]), 32'(8'hFF));
        end

        // 2. Fill, overflow, drain, sticky flag and clear.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h10, 1'b0, 1'b0);
        check_eq("t2_full_level", 32'(level), 32'(DEPTH));
        check_eq("t2_overflow", 32'(overflow), 32'(1));
        popped_q.delete();
        drain();
        check_eq("t2_count", 32'(popped_q.size()), 32'(DEPTH));
        foreach (popped_q[i]) check_eq("t2_byte", 32'(popped_q[i]), 32'(i));
        idle(3);
        check_eq("t2_sticky", 32'(overflow), 32'(1));
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_eq("t2_cleared", 32'(overflow), 32'(0));

        // 3. Full with simultaneous push and pop: pop wins, push dropped.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        check_eq("t3_level", 32'(level), 32'(DEPTH - 1));
        check_eq("t3_overflow", 32'(overflow), 32'(1));
        check_eq("t3_head", 32'(read_data), 32'(8'h01));
        drain();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // 4. Streaming with wrap-around from an LFSR source.
        lfsr = 8'h01;
        lfsr_seq.delete();
        popped_q.delete();
        for (int c = 0; c < 40 * 3; c++) begin
            logic rr;
            rr = ((c / 2) % 2) == 1;
            if (c % 3 == 0) begin
                lfsr_seq.push_back(lfsr);
                cycle(1'b1, lfsr, rr, 1'b0);
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
                cycle(1'b0, 8'h00, rr, 1'b0);
            end
        end
        drain();
        check_eq("t4_count", 32'(popped_q.size()), 32'(40));
        foreach (popped_q[i]) begin
            if (i < lfsr_seq.size()) check_eq("t4_byte", 32'(popped_q[i]), 32'(lfsr_seq[i]));
        end
        check_eq("t4_no_overflow", 32'(overflow), 32'(0));

        // 5. Reset mid-operation.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h55, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        check_eq("t5_after_reset", 32'(read_data), 32'(8'h42));
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            cycle(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 8'($urandom()),
                  ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0);
        end
        drain();

`ifdef UART_RX_FIFO_DROP_COUNT_EN
        // 6. Drop counter: count, clear-with-drop, saturation.
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hDD, 1'b0, 1'b0);
        check_eq("t6_three", 32'(drop_count), 32'(3));
        cycle(1'b1, 8'hDD, 1'b0, 1'b1);
        check_eq("t6_clear_drop_cnt", 32'(drop_count), 32'(1));
        check_eq("t6_clear_drop_ovf", 32'(overflow), 32'(1));
        for (int i = 0; i < 65540; i++) cycle(1'b1, 8'hDD, 1'b0, 1'b0);
        check_eq("t6_saturate", 32'(drop_count), 32'(16'hFFFF));
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
